// File: rtl/npu_wb_pkg.sv
// npu_wb_pkg: shared state/mode encodings and size helpers for the result writeback engine
package npu_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int vec_width(input int lanes, input int prec);
        return lanes * prec;
    endfunction

    function automatic int beat_count(input int vec_w, input int dw);
        return vec_w / dw;
    endfunction

endpackage

// File: rtl/wb_beat_serializer.sv
// wb_beat_serializer: holds one result vector and presents it lowest beat first
module wb_beat_serializer import npu_wb_pkg::*; #(
    parameter int VEC_W       = 64,
    parameter int DRAM_DWIDTH = 32,
    localparam int BEATS      = beat_count(VEC_W, DRAM_DWIDTH),
    localparam int BW         = min1_clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   advance_i,
    input  logic [VEC_W-1:0]       data_i,
    output logic [BW-1:0]          beat_o,
    output logic                   last_o,
    output logic [DRAM_DWIDTH-1:0] next_data_o
);
    logic [VEC_W-1:0] hold_q;
    logic [BW-1:0]    beat_q;
    logic [BW-1:0]    beat_d;

    assign beat_o = beat_q;
    assign last_o = beat_q == BW'(BEATS - 1);
    assign beat_d = last_o ? '0 : beat_q + BW'(1);
    // beat 0 bypasses the holding register so it can be registered on the handshake edge
    assign next_data_o = load_i ? data_i[DRAM_DWIDTH-1:0] : hold_q[beat_d*DRAM_DWIDTH +: DRAM_DWIDTH];

    // capture a vector on handshake, then step through its beats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            beat_q <= '0;
        end else if (load_i) begin
            hold_q <= data_i;
            beat_q <= '0;
        end else if (advance_i) begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/npu_result_writeback.sv
// npu_result_writeback: collects tile result vectors and writes them to DRAM as strided beats
module npu_result_writeback import npu_wb_pkg::*; #(
    parameter int NUM_TILES     = 2,
    parameter int NUM_LDPES     = 4,
    parameter int OUT_PRECISION = 16,
    parameter int DRAM_DWIDTH   = 32,
    parameter int DRAM_AWIDTH   = 10,
    parameter int CNT_W         = 8,
    localparam int VEC_W        = vec_width(NUM_LDPES, OUT_PRECISION),
    localparam int CH_W         = min1_clog2(NUM_TILES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [CH_W-1:0]            tile_sel,
    input  logic [DRAM_AWIDTH-1:0]     base_addr,
    input  logic [DRAM_AWIDTH-1:0]     stride,
    input  logic [CNT_W-1:0]           num_vectors,
    input  logic [NUM_TILES*VEC_W-1:0] in_data,
    input  logic [NUM_TILES-1:0]       in_valid,
    output logic [NUM_TILES-1:0]       in_ready,
    output logic [DRAM_AWIDTH-1:0]     dram_addr,
    output logic [DRAM_DWIDTH-1:0]     output_data_DRAM,
    output logic                       dram_write_enable,
    output logic                       busy,
    output logic                       done
);
    localparam int BW = min1_clog2(beat_count(VEC_W, DRAM_DWIDTH));

    state_t                 state_q, state_d;
    logic                   mode_q;
    logic [CH_W-1:0]        ch_q;
    logic [DRAM_AWIDTH-1:0] vec_addr_q, stride_q, addr_q;
    logic [CNT_W-1:0]       num_q, cnt_q;
    logic                   we_q;
    logic [DRAM_DWIDTH-1:0] data_q;
    logic                   hs, writing, last;
    logic [BW-1:0]          beat;
    logic [DRAM_DWIDTH-1:0] next_data;
    logic [VEC_W-1:0]       slice;

    assign hs      = state_q == S_WAIT && in_valid[ch_q];
    assign writing = state_q == S_WRITE;
    assign slice   = in_data[ch_q*VEC_W +: VEC_W];

    assign dram_addr         = addr_q;
    assign output_data_DRAM  = data_q;
    assign dram_write_enable = we_q;

    wb_beat_serializer #(
        .VEC_W       (VEC_W),
        .DRAM_DWIDTH (DRAM_DWIDTH)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load_i      (hs),
        .advance_i   (writing),
        .data_i      (slice),
        .beat_o      (beat),
        .last_o      (last),
        .next_data_o (next_data)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (num_vectors == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (hs) state_d = S_WRITE;
            S_WRITE: if (last) state_d = (cnt_q + CNT_W'(1) == num_q) ? S_DONE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // status and one-hot ready for the channel currently being served
    always_comb begin
        busy = state_q != S_IDLE;
        done = state_q == S_DONE;
        for (int i = 0; i < NUM_TILES; i++) in_ready[i] = state_q == S_WAIT && ch_q == CH_W'(i);
    end

    // command latch, vector/channel/address bookkeeping and registered DRAM port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_SINGLE;
            ch_q       <= '0;
            vec_addr_q <= '0;
            stride_q   <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                mode_q     <= mode;
                stride_q   <= stride;
                num_q      <= num_vectors;
                cnt_q      <= '0;
                vec_addr_q <= base_addr;
                ch_q       <= (mode == MODE_RR) ? '0 : tile_sel;
            end
            if (writing && last) begin
                cnt_q      <= cnt_q + CNT_W'(1);
                vec_addr_q <= vec_addr_q + stride_q;
                if (mode_q == MODE_RR) ch_q <= (ch_q == CH_W'(NUM_TILES - 1)) ? '0 : ch_q + CH_W'(1);
            end
            we_q <= hs || (writing && !last);
            if (hs) begin
                addr_q <= vec_addr_q;
                data_q <= next_data;
            end else if (writing && !last) begin
                addr_q <= vec_addr_q + DRAM_AWIDTH'(beat) + DRAM_AWIDTH'(1);
                data_q <= next_data;
            end
        end
    end

endmodule

// File: tb/tb_npu_result_writeback.sv
// tb_npu_result_writeback: directed commands checked against a queue-based write model
module tb_npu_result_writeback;
    localparam int NT = 2;
    localparam int VW = 64;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 8;
    localparam int BEATS = VW / DW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset, start, mode;
    logic [0:0]      tile_sel;
    logic [AW-1:0]   base_addr, stride;
    logic [CW-1:0]   num_vectors;
    logic [NT*VW-1:0] in_data;
    logic [NT-1:0]   in_valid, in_ready;
    logic [AW-1:0]   dram_addr;
    logic [DW-1:0]   output_data_DRAM;
    logic            dram_write_enable, busy, done;

    int   tests = 0;
    int   fails = 0;
    int   dones = 0;
    int   hs_cnt = 0;
    wr_t  exp_q[$];
    int   exp_ch[$];

    npu_result_writeback #(
        .NUM_TILES(NT), .NUM_LDPES(4), .OUT_PRECISION(16),
        .DRAM_DWIDTH(DW), .DRAM_AWIDTH(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .tile_sel(tile_sel),
        .base_addr(base_addr), .stride(stride), .num_vectors(num_vectors),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dram_addr(dram_addr), .output_data_DRAM(output_data_DRAM),
        .dram_write_enable(dram_write_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] vec_of(input int c, input int k);
        return 64'hAAAA_BBBB_CCCC_DDDD ^ {4'(c ^ 1), 28'h0, 4'(k), 28'h0};
    endfunction

    // every channel offers the vector that would be the next one taken
    always_comb begin
        in_data = '0;
        for (int c = 0; c < NT; c++) in_data[c*VW +: VW] = vec_of(c, hs_cnt);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // expected channel order and write stream of a command
    task automatic model(input bit m, input int sel, input int base, input int strd, input int n);
        logic [VW-1:0] v;
        int c;
        hs_cnt = 0;
        for (int k = 0; k < n; k++) begin
            c = m ? k % NT : sel;
            v = vec_of(c, k);
            exp_ch.push_back(c);
            for (int b = 0; b < BEATS; b++) exp_q.push_back({AW'(base + k * strd + b), v[b*DW +: DW]});
        end
    endtask

    task automatic monitor();
        bit  hs;
        wr_t w;
        logic [NT-1:0] oh;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (!reset) begin
                if (in_ready != '0) begin
                    if (exp_ch.size() == 0) chk("ready_unexpected", 64'(in_ready), 64'(0));
                    else begin
                        oh = NT'(1) << exp_ch[0];
                        chk("ready_channel", 64'(in_ready), 64'(oh));
                    end
                    hs = |(in_ready & in_valid);
                    if (hs && exp_ch.size() > 0) void'(exp_ch.pop_front());
                end
                if (dram_write_enable) begin
                    if (exp_q.size() == 0) chk("write_unexpected", 64'({dram_addr, output_data_DRAM}), 64'(0));
                    else begin
                        w = exp_q.pop_front();
                        chk("write_addr_data", 64'({dram_addr, output_data_DRAM}), 64'(w));
                    end
                end
                if (done) begin
                    dones++;
                    chk("done_after_all_writes", 64'({busy, 8'(exp_q.size()), 8'(exp_ch.size())}), 64'({1'b1, 16'h0}));
                end
            end
            @(posedge clk);
            #1;
            if (hs) hs_cnt++;
        end
    endtask

    task automatic run_cmd(input bit m, input int sel, input int base, input int strd, input int n,
                           input bit stall, input int exp_t);
        int d0, t;
        d0 = dones;
        mode = m;
        tile_sel = 1'(sel);
        base_addr = AW'(base);
        stride = AW'(strd);
        num_vectors = CW'(n);
        if (stall) in_valid = ~(NT'(1) << sel);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                chk("stall_busy_no_write", 64'({busy, dram_write_enable}), 64'(2'b10));
                start = (i % 2 == 0);
                base_addr = '0;
                num_vectors = 8'd9;
                tick();
                start = 1'b0;
            end
            in_valid = '1;
        end
        t = 0;
        while (!done && t < 200) begin
            tick();
            t++;
        end
        chk("cycles_to_done", 64'(t), 64'(exp_t));
        tick();
        chk("idle_after_done", 64'({busy, done, dram_write_enable}), 64'(0));
        chk("one_done_pulse", 64'(dones - d0), 64'(1));
    endtask

    initial begin
        int t, d0;
        reset = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        tile_sel = '0;
        base_addr = '0;
        stride = '0;
        num_vectors = '0;
        in_valid = '1;
        fork
            monitor();
        join_none
        tick();
        tick();
        chk("reset_outputs", 64'({in_ready, dram_addr, output_data_DRAM, dram_write_enable, busy, done}), 64'(0));
        reset = 1'b0;
        tick();
        chk("idle_after_reset", 64'({busy, done, in_ready}), 64'(0));

        model(0, 1, 'h10, 4, 3);
        chk("pin_t1_w0", 64'(exp_q[0]), 64'({10'h010, 32'hCCCC_DDDD}));
        chk("pin_t1_w1", 64'(exp_q[1]), 64'({10'h011, 32'hAAAA_BBBB}));
        chk("pin_t1_w2", 64'(exp_q[2]), 64'({10'h014, 32'hDCCC_DDDD}));
        chk("pin_t1_w5", 64'(exp_q[5]), 64'({10'h019, 32'hAAAA_BBBB}));
        run_cmd(0, 1, 'h10, 4, 3, 0, 9);

        model(1, 0, 'h100, 'h20, 4);
        chk("pin_rr_order", 64'({4'(exp_ch[0]), 4'(exp_ch[1]), 4'(exp_ch[2]), 4'(exp_ch[3])}), 64'(16'h0101));
        chk("pin_rr_addr", 64'({exp_q[2].a, exp_q[7].a}), 64'({10'h120, 10'h161}));
        run_cmd(1, 0, 'h100, 'h20, 4, 0, 12);

        model(0, 1, 'h200, 'h10, 2);
        run_cmd(0, 1, 'h200, 'h10, 2, 1, 6);

        model(0, 0, 'h3FE, 1, 2);
        chk("pin_wrap", 64'({exp_q[0].a, exp_q[1].a, exp_q[2].a, exp_q[3].a}),
            64'({10'h3FE, 10'h3FF, 10'h3FF, 10'h000}));
        run_cmd(0, 0, 'h3FE, 1, 2, 0, 6);

        model(1, 0, 'h55, 3, 0);
        run_cmd(1, 0, 'h55, 3, 0, 0, 0);

        model(0, 0, 'h40, 8, 2);
        d0 = dones;
        mode = 1'b0;
        tile_sel = '0;
        base_addr = 10'h040;
        stride = 10'h008;
        num_vectors = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (!dram_write_enable && t < 20) begin
            tick();
            t++;
        end
        tick();
        chk("second_beat", 64'({dram_write_enable, dram_addr}), 64'({1'b1, 10'h041}));
        #1 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({in_ready, dram_addr, output_data_DRAM, dram_write_enable, busy, done}), 64'(0));
        exp_q.delete();
        exp_ch.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("no_done_after_reset", 64'({8'(dones - d0), busy, dram_write_enable}), 64'(0));

        model(1, 0, 'h300, 2, 2);
        run_cmd(1, 0, 'h300, 2, 2, 0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
